// File: rtl/regfile_pkg.sv
// Shared defaults, write-port payload and the operand source-select helper.
package regfile_pkg;

  localparam int unsigned DEF_DW     = 16;
  localparam int unsigned DEF_RN     = 8;
  localparam int unsigned DEF_AW     = 3;
  localparam int unsigned DEF_PC_ADR = 3;
  localparam logic [DEF_DW-1:0] DEF_SF_RST = 16'h0;

  // Widest data/address the select helper handles; callers cast in and out.
  localparam int unsigned SEL_DW = 64;
  localparam int unsigned SEL_AW = 8;

  typedef logic [SEL_DW-1:0] sel_word_t;
  typedef logic [SEL_AW-1:0] sel_adr_t;

  typedef struct packed {
    logic      wr;
    sel_adr_t  adr;
    sel_word_t data;
  } wr_port_t;

  // Operand source: PC alias, then wb bypass, then wa bypass, then bank.
  function automatic sel_word_t src_sel(input sel_adr_t  adr,
                                        input sel_adr_t  pc_adr,
                                        input sel_word_t pc,
                                        input wr_port_t  wa,
                                        input wr_port_t  wb,
                                        input sel_word_t bank);
    sel_word_t res;
    res = bank;
    if (adr == pc_adr)                res = pc;
    else if (wb.wr && wb.adr == adr)  res = wb.data;
    else if (wa.wr && wa.adr == adr)  res = wa.data;
    return res;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: read request/response, two write ports, scoreboard and flags.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned RN = DEF_RN,
  parameter int unsigned AW = DEF_AW
);
  logic          rd_valid;
  logic [AW-1:0] rd_a_adr;
  logic [AW-1:0] rd_b_adr;
  logic [DW-1:0] rd_pc;
  logic          rd_ready;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic          rd_out_vld;
  logic          resv_wr;
  logic [AW-1:0] resv_adr;
  logic          wa_wr;
  logic [AW-1:0] wa_adr;
  logic [DW-1:0] wa_data;
  logic          wb_wr;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_data;
  logic          sf_alu_wr;
  logic [DW-1:0] sf_alu;
  logic          sf_rmw_wr;
  logic [DW-1:0] sf_rmw;
  logic [RN-1:0] busy;
  logic [DW-1:0] flags;

  modport master (
    output rd_valid, rd_a_adr, rd_b_adr, rd_pc, resv_wr, resv_adr,
           wa_wr, wa_adr, wa_data, wb_wr, wb_adr, wb_data,
           sf_alu_wr, sf_alu, sf_rmw_wr, sf_rmw,
    input  rd_ready, rd_a, rd_b, rd_out_vld, busy, flags
  );

  modport slave (
    input  rd_valid, rd_a_adr, rd_b_adr, rd_pc, resv_wr, resv_adr,
           wa_wr, wa_adr, wa_data, wb_wr, wb_adr, wb_data,
           sf_alu_wr, sf_alu, sf_rmw_wr, sf_rmw,
    output rd_ready, rd_a, rd_b, rd_out_vld, busy, flags
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register plus per-source ok.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned RN     = DEF_RN,
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned PC_ADR = DEF_PC_ADR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          resv_wr,
  input  logic [AW-1:0] resv_adr,
  input  logic          wa_wr,
  input  logic [AW-1:0] wa_adr,
  input  logic          wb_wr,
  input  logic [AW-1:0] wb_adr,
  input  logic [AW-1:0] a_adr,
  input  logic [AW-1:0] b_adr,
  output logic [RN-1:0] busy,
  output logic          a_ok_c,
  output logic          b_ok_c
);
  localparam logic [AW-1:0] PC_IDX = AW'(PC_ADR);

  logic [RN-1:0] busy_q;
  logic [RN-1:0] busy_d;

  // Clear on write, set on reservation (set wins), PC never busy.
  always_comb begin
    busy_d = busy_q;
    if (wa_wr)   busy_d[wa_adr]   = 1'b0;
    if (wb_wr)   busy_d[wb_adr]   = 1'b0;
    if (resv_wr) busy_d[resv_adr] = 1'b1;
    busy_d[PC_IDX] = 1'b0;
  end

  // Source usable if PC, not pending, or written this cycle; no resv_wr path.
  always_comb begin
    a_ok_c = (a_adr == PC_IDX) | ~busy_q[a_adr] |
             (wa_wr & (wa_adr == a_adr)) | (wb_wr & (wb_adr == a_adr));
    b_ok_c = (b_adr == PC_IDX) | ~busy_q[b_adr] |
             (wa_wr & (wa_adr == b_adr)) | (wb_wr & (wb_adr == b_adr));
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with scoreboard, bypass and flag register.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned   DW     = DEF_DW,
  parameter int unsigned   RN     = DEF_RN,
  parameter int unsigned   AW     = $clog2(RN),
  parameter int unsigned   PC_ADR = DEF_PC_ADR,
  parameter logic [DW-1:0] SF_RST = DW'(DEF_SF_RST)
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam logic [AW-1:0] PC_IDX = AW'(PC_ADR);

  logic [DW-1:0] regs_q [RN];
  logic [DW-1:0] regs_d [RN];
  logic [DW-1:0] rd_a_q, rd_a_d;
  logic [DW-1:0] rd_b_q, rd_b_d;
  logic          rd_out_vld_q, rd_out_vld_d;
  logic [DW-1:0] flags_q, flags_d;
  logic          a_ok_c, b_ok_c;
  logic          rd_ready_c;
  wr_port_t      wa_p, wb_p;

  regfile_scoreboard #(
    .RN     (RN),
    .AW     (AW),
    .PC_ADR (PC_ADR)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .resv_wr  (bus.resv_wr),
    .resv_adr (bus.resv_adr),
    .wa_wr    (bus.wa_wr),
    .wa_adr   (bus.wa_adr),
    .wb_wr    (bus.wb_wr),
    .wb_adr   (bus.wb_adr),
    .a_adr    (bus.rd_a_adr),
    .b_adr    (bus.rd_b_adr),
    .busy     (bus.busy),
    .a_ok_c   (a_ok_c),
    .b_ok_c   (b_ok_c)
  );

  assign rd_ready_c = ~bus.rd_valid | (a_ok_c & b_ok_c);

  // Bank update: wb applied after wa so it wins on a shared index; PC writes dropped.
  always_comb begin
    regs_d = regs_q;
    if (bus.wa_wr && bus.wa_adr != PC_IDX) regs_d[bus.wa_adr] = bus.wa_data;
    if (bus.wb_wr && bus.wb_adr != PC_IDX) regs_d[bus.wb_adr] = bus.wb_data;
  end

  // Read pipeline: capture bypassed operands on accept, otherwise hold.
  always_comb begin
    wa_p         = '{wr: bus.wa_wr, adr: SEL_AW'(bus.wa_adr), data: SEL_DW'(bus.wa_data)};
    wb_p         = '{wr: bus.wb_wr, adr: SEL_AW'(bus.wb_adr), data: SEL_DW'(bus.wb_data)};
    rd_a_d       = rd_a_q;
    rd_b_d       = rd_b_q;
    rd_out_vld_d = bus.rd_valid & rd_ready_c;
    if (rd_out_vld_d) begin
      rd_a_d = DW'(src_sel(SEL_AW'(bus.rd_a_adr), SEL_AW'(PC_ADR), SEL_DW'(bus.rd_pc),
                           wa_p, wb_p, SEL_DW'(regs_q[bus.rd_a_adr])));
      rd_b_d = DW'(src_sel(SEL_AW'(bus.rd_b_adr), SEL_AW'(PC_ADR), SEL_DW'(bus.rd_pc),
                           wa_p, wb_p, SEL_DW'(regs_q[bus.rd_b_adr])));
    end
  end

  // Flag register: RMW over ALU, else hold.
  always_comb begin
    flags_d = flags_q;
    if (bus.sf_rmw_wr)      flags_d = bus.sf_rmw;
    else if (bus.sf_alu_wr) flags_d = bus.sf_alu;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RN); i++) regs_q[i] <= '0;
      rd_a_q       <= '0;
      rd_b_q       <= '0;
      rd_out_vld_q <= 1'b0;
      flags_q      <= SF_RST;
    end else begin
      regs_q       <= regs_d;
      rd_a_q       <= rd_a_d;
      rd_b_q       <= rd_b_d;
      rd_out_vld_q <= rd_out_vld_d;
      flags_q      <= flags_d;
    end
  end

  assign bus.rd_ready   = rd_ready_c;
  assign bus.rd_a       = rd_a_q;
  assign bus.rd_b       = rd_b_q;
  assign bus.rd_out_vld = rd_out_vld_q;
  assign bus.flags      = flags_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: abstract model checked every cycle plus directed literals.
module tb_regfile_sb;
  localparam int unsigned DW = 16;
  localparam int unsigned RN = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned PC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DW(DW), .RN(RN), .AW(AW)) bus ();
  regfile_sb dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;
  bit checking = 1'b0;

  // Model state
  logic [DW-1:0] m_mem [RN];
  logic [RN-1:0] m_busy;
  logic [DW-1:0] m_flags, m_rd_a, m_rd_b;
  logic          m_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit src_ok(input logic [AW-1:0] a);
    return (a == AW'(PC)) || !m_busy[a] ||
           (bus.wa_wr && bus.wa_adr == a) || (bus.wb_wr && bus.wb_adr == a);
  endfunction

  function automatic bit exp_ready();
    return !bus.rd_valid || (src_ok(bus.rd_a_adr) && src_ok(bus.rd_b_adr));
  endfunction

  // Model: the read returns what the register holds once this cycle's writes land.
  always @(posedge clk) begin
    logic [DW-1:0] nxt [RN];
    bit acc;
    if (rst) begin
      for (int i = 0; i < int'(RN); i++) m_mem[i] = '0;
      m_busy = '0; m_flags = 16'h0; m_rd_a = '0; m_rd_b = '0; m_vld = 1'b0;
      checking = 1'b1;
    end else begin
      acc = bus.rd_valid && exp_ready();
      nxt = m_mem;
      if (bus.wa_wr && bus.wa_adr != AW'(PC)) nxt[bus.wa_adr] = bus.wa_data;
      if (bus.wb_wr && bus.wb_adr != AW'(PC)) nxt[bus.wb_adr] = bus.wb_data;
      if (acc) begin
        m_rd_a = (bus.rd_a_adr == AW'(PC)) ? bus.rd_pc : nxt[bus.rd_a_adr];
        m_rd_b = (bus.rd_b_adr == AW'(PC)) ? bus.rd_pc : nxt[bus.rd_b_adr];
      end
      m_vld = acc;
      if (bus.wa_wr) m_busy[bus.wa_adr] = 1'b0;
      if (bus.wb_wr) m_busy[bus.wb_adr] = 1'b0;
      if (bus.resv_wr && bus.resv_adr != AW'(PC)) m_busy[bus.resv_adr] = 1'b1;
      if (bus.sf_rmw_wr)      m_flags = bus.sf_rmw;
      else if (bus.sf_alu_wr) m_flags = bus.sf_alu;
      m_mem = nxt;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_rd_ready",   32'(bus.rd_ready),   32'(exp_ready()));
      chk("cyc_rd_a",       32'(bus.rd_a),       32'(m_rd_a));
      chk("cyc_rd_b",       32'(bus.rd_b),       32'(m_rd_b));
      chk("cyc_rd_out_vld", 32'(bus.rd_out_vld), 32'(m_vld));
      chk("cyc_busy",       32'(bus.busy),       32'(m_busy));
      chk("cyc_flags",      32'(bus.flags),      32'(m_flags));
    end
  end

  task automatic idle();
    bus.rd_valid = 0; bus.rd_a_adr = '0; bus.rd_b_adr = '0; bus.rd_pc = '0;
    bus.resv_wr = 0; bus.resv_adr = '0;
    bus.wa_wr = 0; bus.wa_adr = '0; bus.wa_data = '0;
    bus.wb_wr = 0; bus.wb_adr = '0; bus.wb_data = '0;
    bus.sf_alu_wr = 0; bus.sf_alu = '0; bus.sf_rmw_wr = 0; bus.sf_rmw = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    bus.rd_valid = 1; bus.rd_a_adr = a; bus.rd_b_adr = b;
  endtask

  initial begin
    idle();
    rst = 1; step(); step(); rst = 0;

    // 1: plain read after reset
    rd(3'd1, 3'd2);
    @(negedge clk); chk("t1_ready", 32'(bus.rd_ready), 32'h1);
    step(); idle();
    chk("t1_rd_a", 32'(bus.rd_a), 32'h0);
    chk("t1_rd_b", 32'(bus.rd_b), 32'h0);
    chk("t1_vld", 32'(bus.rd_out_vld), 32'h1);
    chk("t1_flags", 32'(bus.flags), 32'h0);

    // 2: ALU bypass into port A
    rd(3'd2, 3'd5); bus.wa_wr = 1; bus.wa_adr = 3'd2; bus.wa_data = 16'h1234;
    step(); idle();
    chk("t2_rd_a", 32'(bus.rd_a), 32'h1234);
    chk("t2_rd_b", 32'(bus.rd_b), 32'h0);
    step();
    chk("t2_hold_a", 32'(bus.rd_a), 32'h1234);
    chk("t2_vld_low", 32'(bus.rd_out_vld), 32'h0);

    // 3: wb beats wa on same index
    bus.wa_wr = 1; bus.wa_adr = 3'd4; bus.wa_data = 16'hAAAA;
    bus.wb_wr = 1; bus.wb_adr = 3'd4; bus.wb_data = 16'h5555;
    step(); idle();
    rd(3'd4, 3'd2); step(); idle();
    chk("t3_rd_a", 32'(bus.rd_a), 32'h5555);
    chk("t3_rd_b", 32'(bus.rd_b), 32'h1234);

    // 4: stall on pending r6, release by wb bypass
    bus.resv_wr = 1; bus.resv_adr = 3'd6; step(); idle();
    chk("t4_busy6", 32'(bus.busy), 32'h40);
    rd(3'd6, 3'd1);
    @(negedge clk); chk("t4_stall", 32'(bus.rd_ready), 32'h0);
    step();
    chk("t4_hold_a", 32'(bus.rd_a), 32'h5555);
    chk("t4_vld_low", 32'(bus.rd_out_vld), 32'h0);
    bus.wb_wr = 1; bus.wb_adr = 3'd6; bus.wb_data = 16'h00FF;
    @(negedge clk); chk("t4_release", 32'(bus.rd_ready), 32'h1);
    step(); idle();
    chk("t4_rd_a", 32'(bus.rd_a), 32'h00FF);
    chk("t4_rd_b", 32'(bus.rd_b), 32'h0);
    chk("t4_busy_clr", 32'(bus.busy), 32'h0);

    // Set and clear on same index: set wins
    bus.resv_wr = 1; bus.resv_adr = 3'd5;
    bus.wa_wr = 1; bus.wa_adr = 3'd5; bus.wa_data = 16'h0505;
    step(); idle();
    chk("sc_busy5", 32'(bus.busy), 32'h20);
    bus.wa_wr = 1; bus.wa_adr = 3'd5; bus.wa_data = 16'h0506; step(); idle();

    // 5: PC alias, write and reserve of PC ignored
    rd(3'd3, 3'd5); bus.rd_pc = 16'hC000; step(); idle();
    chk("t5_pc", 32'(bus.rd_a), 32'hC000);
    chk("t5_r5", 32'(bus.rd_b), 32'h0506);
    bus.wa_wr = 1; bus.wa_adr = 3'd3; bus.wa_data = 16'hBEEF; step(); idle();
    bus.resv_wr = 1; bus.resv_adr = 3'd3; step(); idle();
    chk("t5_busy_pc", 32'(bus.busy), 32'h0);
    rd(3'd3, 3'd3); bus.rd_pc = 16'h1111;
    @(negedge clk); chk("t5_pc_ready", 32'(bus.rd_ready), 32'h1);
    step(); idle();
    chk("t5_pc2", 32'(bus.rd_b), 32'h1111);

    // 6: flags priority and hold
    bus.sf_alu_wr = 1; bus.sf_alu = 16'h0003; bus.sf_rmw_wr = 1; bus.sf_rmw = 16'h0080;
    step(); idle();
    chk("t6_rmw_wins", 32'(bus.flags), 32'h0080);
    bus.sf_alu_wr = 1; bus.sf_alu = 16'h0003; step(); idle();
    chk("t6_alu", 32'(bus.flags), 32'h0003);
    step();
    chk("t6_hold", 32'(bus.flags), 32'h0003);

    // Reset with pending writes and a read in flight
    for (int i = 4; i < 8; i++) begin
      bus.resv_wr = 1; bus.resv_adr = AW'(i); step();
    end
    idle();
    chk("t6_busy_f0", 32'(bus.busy), 32'hF0);
    rst = 1; rd(3'd1, 3'd2); bus.wa_wr = 1; bus.wa_adr = 3'd1; bus.wa_data = 16'h7777;
    step(); rst = 0; idle();
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_flags", 32'(bus.flags), 32'h0);
    chk("rst_vld", 32'(bus.rd_out_vld), 32'h0);
    chk("rst_rd_a", 32'(bus.rd_a), 32'h0);
    rd(3'd1, 3'd4); step(); idle();
    chk("rst_r1", 32'(bus.rd_a), 32'h0);
    chk("rst_r4", 32'(bus.rd_b), 32'h0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
